// File: rtl/gf180mcu_fd_sc_mcu7t5v0__muxn_sync.sv
// Registered NIN:1 mux whose select changes only through a SREQ/SACK handshake,
// with a programmable break-before-make gap (Z held at zero) between channels.
// Latency: I to Z is 1 cycle; a select change commits GAP cycles after the request edge.
// Backpressure: while BUSY is high, new SREQ pulses are dropped (no queueing).
// Optional macro GF180MCU_FD_SC_MCU7T5V0__MUXN_SYNC_PARITY_EN adds ZP = ^Z (registered).
// Ports: CLK, RN (async active-low), I (NIN*W channel data), S/SREQ (select request),
//        SACK/SERR (one-cycle result pulses), BUSY (gap in progress), SCUR (committed select), Z.
module gf180mcu_fd_sc_mcu7t5v0__muxn_sync #(
  parameter int NIN = 4,
  parameter int W   = 1,
  parameter int GAP = 2,
  localparam int SW = (NIN > 1) ? $clog2(NIN) : 1
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [NIN*W-1:0] I,
  input  logic [SW-1:0]    S,
  input  logic             SREQ,
  output logic             SACK,
  output logic             SERR,
  output logic             BUSY,
  output logic [SW-1:0]    SCUR,
  output logic [W-1:0]     Z
`ifdef GF180MCU_FD_SC_MCU7T5V0__MUXN_SYNC_PARITY_EN
  ,
  output logic             ZP
`endif
);

  typedef enum logic {ST_ACTIVE, ST_GAP} state_t;

  localparam logic [SW:0] NIN_V    = (SW + 1)'(NIN);
  localparam logic [3:0]  CNT_INIT = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [SW-1:0]   r_pend;
  logic [SW-1:0]   r_scur;
  logic [W-1:0]    r_z;
  logic            r_sack;
  logic            r_serr;
  logic            r_busy;

  logic            w_s_ok;
  logic            w_switch;
  logic [W-1:0]    w_cur_dat;
  logic [W-1:0]    w_req_dat;
  logic [W-1:0]    w_pend_dat;
  logic [W-1:0]    w_z_nxt;

  // Loop-based mux: out-of-range selects (NIN not a power of two) yield zero
  // instead of reading past the end of I.
  function automatic logic [W-1:0] f_pick(input logic [NIN*W-1:0] din,
                                          input logic [SW-1:0]    sel);
    f_pick = '0;
    for (int k = 0; k < NIN; k++) begin
      if (sel == SW'(k)) f_pick = din[k*W +: W];
    end
  endfunction

  assign w_cur_dat  = f_pick(I, r_scur);
  assign w_req_dat  = f_pick(I, S);
  assign w_pend_dat = f_pick(I, r_pend);

  assign w_s_ok   = ({1'b0, S} < NIN_V);
  // A real channel change; only meaningful in ACTIVE with SREQ high.
  assign w_switch = SREQ && w_s_ok && (S != r_scur);

  // Next value of Z; shared by Z and the optional parity bit so both load together.
  always_comb begin
    w_z_nxt = w_cur_dat;
    if (r_state == ST_GAP) begin
      w_z_nxt = (r_cnt == 4'd0) ? w_pend_dat : '0;
    end else if (w_switch) begin
      w_z_nxt = (GAP == 0) ? w_req_dat : '0;
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state <= ST_ACTIVE;
      r_cnt   <= 4'd0;
      r_pend  <= '0;
      r_scur  <= '0;
      r_z     <= '0;
      r_sack  <= 1'b0;
      r_serr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_z    <= w_z_nxt;
      r_sack <= 1'b0;
      r_serr <= 1'b0;
      case (r_state)
        ST_ACTIVE: begin
          if (SREQ) begin
            if (!w_s_ok) begin
              r_serr <= 1'b1;
            end else if (S == r_scur) begin
              r_sack <= 1'b1;
            end else if (GAP == 0) begin
              r_scur <= S;
              r_sack <= 1'b1;
            end else begin
              r_pend  <= S;
              r_cnt   <= CNT_INIT;
              r_state <= ST_GAP;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          // SREQ is deliberately ignored here: the requester waits for SACK.
          if (r_cnt == 4'd0) begin
            r_scur  <= r_pend;
            r_sack  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_ACTIVE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= ST_ACTIVE;
      endcase
    end
  end

`ifdef GF180MCU_FD_SC_MCU7T5V0__MUXN_SYNC_PARITY_EN
  logic r_zp;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) r_zp <= 1'b0;
    else     r_zp <= ^w_z_nxt;
  end

  assign ZP = r_zp;
`endif

  assign SACK = r_sack;
  assign SERR = r_serr;
  assign BUSY = r_busy;
  assign SCUR = r_scur;
  assign Z    = r_z;

endmodule
